mux_arb_stream: RTL and testbench

//  Parametrised N-channel, WIDTH-bit stream multiplexer with a registered output and valid/ready handshakes.
//  It supersedes the fixed 8:1 combinational word mux wherever sources are bursty and need flow control.
//  Two modes:
//   - FIXED: the external sel picks the channel.
//   - RR: round-robin arbitration across all requesting channels.
//  It sits between producer blocks and a single shared consumer such as a display bus or serial TX.

---
 rtl/mux_arb_pkg.sv | 12 +
 rtl/mux_arb_stream_rr_pick.sv | 31 +++
 rtl/mux_arb_stream.sv | 85 ++++++++
 tb/tb_mux_arb_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the N-channel stream multiplexer.
package mux_arb_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Sliced down to WIDTH by users; 64 bits covers any realistic channel width.
  localparam logic [63:0] RESET_DATA = '0;

endpackage : mux_arb_pkg

// File: rtl/mux_arb_stream_rr_pick.sv
// Rotating-priority picker: grants the first requester after ptr, wrapping modulo N_CH.
module rr_pick #(
  parameter  int N_CH  = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt,
  output logic             gnt_vld
);

  logic [N_CH-1:0] req_hi;

  // Requests strictly above ptr win first; otherwise the lowest request wraps around.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    req_hi  = '0;
    gnt     = '0;
    gnt_vld = |req;
    for (int i = 0; i < N_CH; i++) begin
      req_hi[i] = req[i] && (SEL_W'(i) > ptr);
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) gnt = SEL_W'(i);
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_hi[i]) gnt = SEL_W'(i);
    end
  end

endmodule : rr_pick

// File: rtl/mux_arb_stream.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration
// and a single registered output slot.
module mux_arb_stream
  import mux_arb_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int WIDTH = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  mux_mode_e        mode_e;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_gnt;
  logic             rr_vld;
  logic             fix_vld;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;
  logic [WIDTH-1:0] gnt_data;
  logic             load_en;

  assign mode_e  = mux_mode_e'(mode);
  assign load_en = !out_valid || out_ready;

  rr_pick #(.N_CH(N_CH)) u_rr_pick (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_vld (rr_vld)
  );

  // A sel beyond the last channel matches no index and therefore grants nothing.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) fix_vld = in_valid[i];
    end
  end

  assign gnt     = (mode_e == MODE_RR) ? rr_gnt : sel;
  assign gnt_vld = (mode_e == MODE_RR) ? rr_vld : fix_vld;

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = gnt_vld && load_en;
      end
    end
  end

  // rr_ptr resets to the last channel so the first round-robin search starts at channel 0.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= RESET_DATA[WIDTH-1:0];
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(N_CH - 1);
    end else if (load_en) begin
      if (gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt;
        if (mode_e == MODE_RR) rr_ptr <= gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule : mux_arb_stream

// File: tb/tb_mux_arb_stream.sv
// Randomized and directed checks of mux_arb_stream at N_CH = 8, 5 and 3 against a behavioural model.
module tb_mux_arb_stream;

  logic clk = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_inst
    localparam int N   = (g == 0) ? 8 : (g == 1) ? 5 : 3;
    localparam int SW  = $clog2(N);
    localparam int OOR = (N + 1 < (1 << SW)) ? N + 1 : N;

    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic          out_ready = 1'b0;
    logic [SW-1:0] sel = '0;
    logic [N*4-1:0] in_data = '0;
    logic [N-1:0]  in_valid = '0;
    logic [N-1:0]  in_ready;
    logic [3:0]    out_data;
    logic [SW-1:0] out_ch;
    logic          out_valid;

    bit started = 0, rot_done = 0, dir_done = 0, done = 0;

    // Model: one output slot plus the last round-robin winner.
    bit         m_valid = 0;
    logic [3:0] m_data = '0;
    int         m_ch = 0;
    int         m_ptr = N - 1;
    bit         u_gv;
    int         u_gi;

    mux_arb_stream #(.N_CH(N), .WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
    );

    function automatic void model_grant(output bit gv, output int gi);
      int c;
      gv = 0;
      gi = 0;
      if (mode == 1'b0) begin
        if (int'(sel) < N && in_valid[sel]) begin
          gv = 1;
          gi = int'(sel);
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (!gv && in_valid[c]) begin
            gv = 1;
            gi = c;
          end
        end
      end
    endfunction

    function automatic logic [N-1:0] model_ready();
      bit gv;
      int gi;
      logic [N-1:0] r;
      r = '0;
      model_grant(gv, gi);
      if ((!m_valid || out_ready) && gv) r[gi] = 1'b1;
      return r;
    endfunction

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_valid = 0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = N - 1;
      end else if (!m_valid || out_ready) begin
        model_grant(u_gv, u_gi);
        if (u_gv) begin
          m_valid = 1;
          m_data  = in_data[u_gi*4 +: 4];
          m_ch    = u_gi;
          if (mode) m_ptr = u_gi;
        end else begin
          m_valid = 0;
        end
      end
    end

    always @(negedge clk) begin
      if (started && !rst) begin
        check($sformatf("N%0d out_valid", N), out_valid, m_valid);
        check($sformatf("N%0d out_data", N), out_data, m_data);
        check($sformatf("N%0d out_ch", N), out_ch, m_ch);
        check($sformatf("N%0d in_ready", N), in_ready, model_ready());
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic rand_data();
      for (int i = 0; i < N; i++) in_data[i*4 +: 4] = 4'($urandom);
    endtask

    initial begin
      repeat (2) tick();
      check($sformatf("N%0d reset out_valid", N), out_valid, 0);
      check($sformatf("N%0d reset out_data", N), out_data, 0);
      check($sformatf("N%0d reset out_ch", N), out_ch, 0);
      rst = 1'b0;
      started = 1;
      // All channels requesting: the rotation must visit 0..N-1 twice with no bubble.
      mode = 1'b1;
      in_valid = '1;
      out_ready = 1'b1;
      rand_data();
      for (int i = 0; i < 2 * N; i++) begin
        tick();
        check($sformatf("N%0d rot valid", N), out_valid, 1);
        check($sformatf("N%0d rot ch", N), out_ch, i % N);
      end
      rot_done = 1;
      wait (dir_done);
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(15) == 0) mode = ~mode;
        if ($urandom_range(3) == 0) sel = SW'($urandom_range((1 << SW) - 1));
        case ($urandom_range(2))
          0: in_valid = N'($urandom) & N'($urandom);
          1: in_valid = N'($urandom);
          default: in_valid = N'(1) << $urandom_range(N - 1);
        endcase
        rand_data();
        out_ready = ($urandom_range(3) != 0);
        if ($urandom_range(199) == 0) begin
          rst = 1'b1;
          #2;
          rst = 1'b0;
        end
        tick();
      end
      done = 1;
    end

    if (g == 0) begin : gen_dir
      initial begin
        wait (rot_done);
        // Asynchronous reset while a word is held.
        rst = 1'b1;
        #1;
        check("N8 async rst out_valid", out_valid, 0);
        check("N8 async rst out_data", out_data, 0);
        check("N8 async rst out_ch", out_ch, 0);
        tick();
        rst = 1'b0;
        tick();
        check("N8 post-rst grant", out_ch, 0);
        // Fixed select of channel 3, then an idle channel 5.
        mode = 1'b0;
        sel = 3'd3;
        in_valid = 8'h08;
        rand_data();
        in_data[12 +: 4] = 4'hA;
        @(negedge clk);
        check("N8 fixed in_ready", in_ready, 8'h08);
        tick();
        check("N8 fixed data", out_data, 4'hA);
        check("N8 fixed ch", out_ch, 3);
        sel = 3'd5;
        tick();
        check("N8 fixed idle valid", out_valid, 0);
        // Backpressure: round-robin resumes after ch0, so ch1 is held then ch2 follows.
        mode = 1'b1;
        in_valid = '1;
        for (int i = 0; i < N; i++) in_data[i*4 +: 4] = 4'(i + 5);
        tick();
        check("N8 bp first ch", out_ch, 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("N8 bp in_ready", in_ready, 0);
          tick();
          check("N8 bp hold data", out_data, 4'h6);
          check("N8 bp hold ch", out_ch, 1);
          check("N8 bp hold valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        check("N8 bp release ch", out_ch, 2);
        check("N8 bp release data", out_data, 4'h7);
        // Sparse requesters 6 and 1 with the pointer parked on 6.
        in_valid = 8'h40;
        tick();
        check("N8 sparse park", out_ch, 6);
        in_valid = 8'h42;
        tick();
        check("N8 sparse 1st", out_ch, 1);
        tick();
        check("N8 sparse 2nd", out_ch, 6);
        tick();
        check("N8 sparse 3rd", out_ch, 1);
        dir_done = 1;
      end
    end else begin : gen_oor
      initial begin
        wait (rot_done);
        // A select beyond the last channel grants nothing even with every channel valid.
        mode = 1'b0;
        sel = SW'(OOR);
        in_valid = '1;
        @(negedge clk);
        check($sformatf("N%0d oor in_ready", N), in_ready, 0);
        tick();
        check($sformatf("N%0d oor valid", N), out_valid, 0);
        dir_done = 1;
      end
    end
  end

  initial begin
    for (int c = 0; c < 20000; c++) begin
      if (gen_inst[0].done && gen_inst[1].done && gen_inst[2].done) break;
      @(posedge clk);
    end
    check("all instances finished", {gen_inst[0].done, gen_inst[1].done, gen_inst[2].done}, 3'b111);
    #20;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux_arb_stream
